// File: rtl/countdown_pkg.sv
// Shared types and default widths for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cd_state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PERIOD_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rct,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rct) begin
    if (rct) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter with load handshake, one-cycle done pulse,
// optional auto-reload and a saturating count of completed periods.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
  input  logic                clk,
  input  logic                rct,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                decr,
  input  logic                abort,
  input  logic                auto_reload,
  output logic [WIDTH-1:0]    count_reg,
  output logic                busy,
  output logic                done,
  output logic [PERIOD_W-1:0] periods
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cd_state_t        r_state;
  cd_state_t        w_next_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_next_reload;
  logic             w_load_fire;
  logic             w_in_done;

  always_ff @(posedge clk or posedge rct) begin
    if (rct) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_reload <= w_next_reload;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_reload = r_reload;
    w_load_fire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_load_fire   = 1'b1;
          w_next_count  = load_value;
          w_next_reload = load_value;
          w_next_state  = (load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (decr) begin
          if (r_count > ONE) begin
            w_next_count = r_count - ONE;
          end else begin
            w_next_count = '0;
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (auto_reload && (r_reload != '0)) begin
          w_next_count = r_reload;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_in_done = (r_state == DONE);

  // Period count is cleared by an accepted load and bumped once per DONE cycle.
  sat_counter #(
    .W(PERIOD_W)
  ) u_periods (
    .clk    (clk),
    .rct    (rct),
    .i_clear(w_load_fire),
    .i_inc  (w_in_done),
    .o_count(periods)
  );

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = w_in_done;
  assign count_reg  = r_count;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed checks of countdown_timer against a behavioural model.
module tb_countdown_timer;

  localparam int WIDTH    = 8;
  localparam int PERIOD_W = 8;
  localparam int PMAX     = (1 << PERIOD_W) - 1;

  logic                clk;
  logic                rct;
  logic                load_valid;
  logic                load_ready;
  logic [WIDTH-1:0]    load_value;
  logic                decr;
  logic                abort;
  logic                auto_reload;
  logic [WIDTH-1:0]    count_reg;
  logic                busy;
  logic                done;
  logic [PERIOD_W-1:0] periods;

  countdown_timer #(
    .WIDTH   (WIDTH),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk        (clk),
    .rct        (rct),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .decr       (decr),
    .abort      (abort),
    .auto_reload(auto_reload),
    .count_reg  (count_reg),
    .busy       (busy),
    .done       (done),
    .periods    (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: a busy timer whose count is zero is in its done cycle.
  bit m_busy;
  int m_count;
  int m_reload;
  int m_periods;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_count   = 0;
    m_reload  = 0;
    m_periods = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (load_valid) begin
        m_count   = int'(load_value);
        m_reload  = int'(load_value);
        m_periods = 0;
        m_busy    = 1'b1;
      end
    end else if (m_count == 0) begin
      if (m_periods < PMAX) m_periods++;
      if (abort) m_busy = 1'b0;
      else if (auto_reload && m_reload != 0) m_count = m_reload;
      else m_busy = 1'b0;
    end else begin
      if (abort) m_busy = 1'b0;
      else if (decr) m_count--;
    end
  endtask

  task automatic compare_all();
    check("count", count_reg, m_count);
    check("busy", busy, m_busy);
    check("done", done, (m_busy && m_count == 0));
    check("ready", load_ready, !m_busy);
    check("periods", periods, m_periods);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input bit lv, input int val, input bit d, input bit ab, input bit ar);
    load_valid  = lv;
    load_value  = WIDTH'(val);
    decr        = d;
    abort       = ab;
    auto_reload = ar;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic async_reset();
    rct = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    rct = 1'b0;
  endtask

  initial begin
    int ndone;
    int last_done;
    int gaps;
    int n;
    n_vec = 0;
    n_err = 0;
    model_reset();
    set_in(0, 0, 0, 0, 0);
    rct = 1'b1;
    #2;
    check("rst_count", count_reg, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);
    check("rst_done", done, 0);
    check("rst_periods", periods, 0);
    @(negedge clk);
    rct = 1'b0;

    // Reset mid-run, then a normal load.
    set_in(1, 5, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0);
    tick();
    tick();
    check("pre_rst_count", count_reg, 3);
    async_reset();
    check("midrst_count", count_reg, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", load_ready, 1);
    set_in(1, 3, 0, 0, 0);
    tick();
    check("post_rst_load", count_reg, 3);
    set_in(0, 0, 1, 0, 0);
    run_until_idle(20);

    // Basic countdown of 4 with decr held.
    set_in(1, 4, 1, 0, 0);
    tick();
    check("basic_load", count_reg, 4);
    set_in(0, 0, 1, 0, 0);
    for (int k = 3; k >= 0; k--) begin
      tick();
      check("basic_count", count_reg, k);
      check("basic_done", done, (k == 0));
    end
    tick();
    check("basic_idle", busy, 0);
    check("basic_periods", periods, 1);

    // Gapped decrements with a load offered mid-run.
    set_in(1, 3, 0, 0, 0);
    tick();
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      set_in(1, 9, (i % 2 == 0), 0, 0);
      tick();
      if (done) ndone++;
    end
    check("gapped_dones", ndone, 1);
    set_in(0, 0, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();

    // Auto-reload of 2: a done every 3 cycles, periods saturating.
    set_in(1, 2, 1, 0, 1);
    tick();
    set_in(0, 0, 1, 0, 1);
    last_done = -1;
    gaps = 0;
    for (int c = 0; c < 305 * 3; c++) begin
      tick();
      if (done) begin
        if (last_done >= 0 && gaps < 8) begin
          check("reload_gap", c - last_done, 3);
          gaps++;
        end
        last_done = c;
      end
    end
    check("periods_sat", periods, PMAX);
    set_in(0, 0, 1, 0, 0);
    run_until_idle(20);

    // Abort with a simultaneous decr at count 7.
    set_in(1, 10, 1, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0);
    tick();
    tick();
    tick();
    check("abort_pre", count_reg, 7);
    set_in(0, 0, 1, 1, 0);
    tick();
    check("abort_count", count_reg, 7);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // Abort during DONE with auto_reload.
    set_in(1, 1, 1, 0, 1);
    tick();
    set_in(0, 0, 1, 0, 1);
    tick();
    check("abort_done_pulse", done, 1);
    set_in(0, 0, 1, 1, 1);
    tick();
    check("abort_in_done_busy", busy, 0);
    check("abort_in_done_count", count_reg, 0);

    // Load 0 with auto_reload: done next cycle, then back to IDLE.
    set_in(1, 0, 0, 0, 1);
    tick();
    check("zero_done", done, 1);
    set_in(0, 0, 0, 0, 1);
    tick();
    check("zero_idle", busy, 0);

    // Load 255: full countdown with no wrap.
    set_in(1, 255, 1, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check("full_len", n, 255);
    tick();
    check("full_idle_count", count_reg, 0);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 29) == 0),
             $urandom_range(0, 1) == 1);
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
